// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the microcoded control sequencer:
// FSM states, opcode fields, bus/write-enable codes and the output bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F1   = 4'd1,
        ST_F2   = 4'd2,
        ST_F3   = 4'd3,
        ST_F4   = 4'd4,
        ST_DEC  = 4'd5,
        ST_E1   = 4'd6,
        ST_E2   = 4'd7,
        ST_E3   = 4'd8,
        ST_E4   = 4'd9,
        ST_HALT = 4'd10
    } state_t;

    localparam logic [2:0] CLS_MISC = 3'd0;
    localparam logic [2:0] CLS_MVTO = 3'd1;
    localparam logic [2:0] CLS_MVFR = 3'd2;
    localparam logic [2:0] CLS_ADD  = 3'd3;
    localparam logic [2:0] CLS_SUB  = 3'd4;
    localparam logic [2:0] CLS_INC  = 3'd5;

    localparam logic [2:0] MISC_NOP  = 3'd0;
    localparam logic [2:0] MISC_LDAC = 3'd1;
    localparam logic [2:0] MISC_STAC = 3'd2;
    localparam logic [2:0] MISC_JUMP = 3'd3;
    localparam logic [2:0] MISC_JMPZ = 3'd4;
    localparam logic [2:0] MISC_HALT = 3'd7;

    localparam logic [5:0] OP_LDAC = {CLS_MISC, MISC_LDAC};
    localparam logic [5:0] OP_STAC = {CLS_MISC, MISC_STAC};
    localparam logic [5:0] OP_HALT = {CLS_MISC, MISC_HALT};

    localparam logic [2:0] RI_R1 = 3'd0;
    localparam logic [2:0] RI_R2 = 3'd1;
    localparam logic [2:0] RI_R3 = 3'd2;
    localparam logic [2:0] RI_RA = 3'd3;
    localparam logic [2:0] RI_RB = 3'd4;
    localparam logic [2:0] RI_RC = 3'd5;
    localparam logic [2:0] RI_AC = 3'd6;

    localparam logic [3:0] WE_AC = 4'd0;
    localparam logic [3:0] WE_AR = 4'd1;
    localparam logic [3:0] WE_DR = 4'd2;
    localparam logic [3:0] WE_R3 = 4'd3;
    localparam logic [3:0] WE_R2 = 4'd4;
    localparam logic [3:0] WE_R1 = 4'd5;
    localparam logic [3:0] WE_RC = 4'd6;
    localparam logic [3:0] WE_RB = 4'd7;
    localparam logic [3:0] WE_RA = 4'd8;
    localparam logic [3:0] WE_PC = 4'd9;

    localparam logic [3:0] SEL_AR = 4'd0;
    localparam logic [3:0] SEL_DR = 4'd1;
    localparam logic [3:0] SEL_R1 = 4'd2;
    localparam logic [3:0] SEL_R2 = 4'd3;
    localparam logic [3:0] SEL_R3 = 4'd4;
    localparam logic [3:0] SEL_RA = 4'd5;
    localparam logic [3:0] SEL_RB = 4'd6;
    localparam logic [3:0] SEL_RC = 4'd7;
    localparam logic [3:0] SEL_AC = 4'd8;
    localparam logic [3:0] SEL_PC = 4'd9;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_PASS = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;

    typedef struct packed {
        logic [9:0] c_bus_we;
        logic [3:0] bus_sel;
        logic       pc_inc;
        logic       ac_inc;
        logic       ra_inc;
        logic       rb_inc;
        logic       rc_inc;
        logic       ldir;
        logic       dr_read;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctrl_out_t;

    function automatic logic opcode_illegal(input logic [5:0] op);
        logic [2:0] cls;
        logic [2:0] idx;
        logic       bad;
        cls = op[5:3];
        idx = op[2:0];
        bad = 1'b0;
        case (cls)
            CLS_MISC: bad = !(idx inside {MISC_NOP, MISC_LDAC, MISC_STAC,
                                          MISC_JUMP, MISC_JMPZ, MISC_HALT});
            CLS_MVTO, CLS_MVFR, CLS_ADD, CLS_SUB:
                bad = (idx == RI_AC) || (idx == 3'd7);
            CLS_INC:  bad = !(idx inside {RI_RA, RI_RB, RI_RC, RI_AC});
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Number of EXEC states an opcode occupies; everything but LDAC/STAC is one.
    function automatic logic [2:0] exec_len(input logic [5:0] op);
        logic [2:0] len;
        len = 3'd1;
        if (op == OP_LDAC) len = 3'd4;
        if (op == OP_STAC) len = 3'd3;
        return len;
    endfunction

    function automatic logic [3:0] reg_we_bit(input logic [2:0] idx);
        logic [3:0] b;
        case (idx)
            RI_R1:   b = WE_R1;
            RI_R2:   b = WE_R2;
            RI_R3:   b = WE_R3;
            RI_RA:   b = WE_RA;
            RI_RB:   b = WE_RB;
            RI_RC:   b = WE_RC;
            default: b = WE_AC;
        endcase
        return b;
    endfunction

    function automatic logic [3:0] reg_sel(input logic [2:0] idx);
        logic [3:0] s;
        case (idx)
            RI_R1:   s = SEL_R1;
            RI_R2:   s = SEL_R2;
            RI_R3:   s = SEL_R3;
            RI_RA:   s = SEL_RA;
            RI_RB:   s = SEL_RB;
            RI_RC:   s = SEL_RC;
            default: s = SEL_AC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Pure combinational microcode ROM: maps state, latched opcode and z_flag
// onto the complete datapath control vector.
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       z_flag,
    output ctrl_out_t  outs
);

    logic [2:0] cls;
    logic [2:0] idx;
    logic       bad;

    assign cls = opcode[5:3];
    assign idx = opcode[2:0];
    assign bad = opcode_illegal(opcode);

    always_comb begin
        outs = '0;
        case (state)
            ST_F1: begin
                outs.bus_sel        = SEL_PC;
                outs.alu_op         = ALU_PASS;
                outs.c_bus_we[WE_AR] = 1'b1;
            end
            ST_F2: begin
                outs.mem_read = 1'b1;
                outs.pc_inc   = 1'b1;
            end
            ST_F3: begin
                outs.mem_read = 1'b1;
                outs.dr_read  = 1'b1;
            end
            ST_F4: outs.ldir = 1'b1;
            ST_HALT: outs.halted = 1'b1;
            ST_E1: begin
                if (bad) begin
                    outs.illegal = 1'b1;
                end else begin
                    case (cls)
                        CLS_MISC: begin
                            if (idx == MISC_LDAC || idx == MISC_STAC) begin
                                outs.bus_sel         = SEL_RA;
                                outs.alu_op          = ALU_PASS;
                                outs.c_bus_we[WE_AR] = 1'b1;
                            end else if (idx == MISC_JUMP ||
                                         (idx == MISC_JMPZ && z_flag)) begin
                                outs.bus_sel         = SEL_RA;
                                outs.alu_op          = ALU_PASS;
                                outs.c_bus_we[WE_PC] = 1'b1;
                            end
                        end
                        CLS_MVTO: begin
                            outs.bus_sel                   = SEL_AC;
                            outs.alu_op                    = ALU_PASS;
                            outs.c_bus_we[reg_we_bit(idx)] = 1'b1;
                        end
                        CLS_MVFR, CLS_ADD, CLS_SUB: begin
                            outs.bus_sel         = reg_sel(idx);
                            outs.alu_op          = (cls == CLS_MVFR) ? ALU_PASS :
                                                   (cls == CLS_ADD)  ? ALU_ADD : ALU_SUB;
                            outs.c_bus_we[WE_AC] = 1'b1;
                        end
                        CLS_INC: begin
                            outs.ra_inc = (idx == RI_RA);
                            outs.rb_inc = (idx == RI_RB);
                            outs.rc_inc = (idx == RI_RC);
                            outs.ac_inc = (idx == RI_AC);
                        end
                        default: ;
                    endcase
                end
            end
            ST_E2: begin
                if (opcode == OP_LDAC) begin
                    outs.mem_read = 1'b1;
                end else if (opcode == OP_STAC) begin
                    outs.bus_sel         = SEL_AC;
                    outs.alu_op          = ALU_PASS;
                    outs.c_bus_we[WE_DR] = 1'b1;
                end
            end
            ST_E3: begin
                if (opcode == OP_LDAC) begin
                    outs.mem_read = 1'b1;
                    outs.dr_read  = 1'b1;
                end else if (opcode == OP_STAC) begin
                    outs.mem_write = 1'b1;
                end
            end
            ST_E4: begin
                if (opcode == OP_LDAC) begin
                    outs.bus_sel         = SEL_DR;
                    outs.alu_op          = ALU_PASS;
                    outs.c_bus_we[WE_AC] = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch-decode-execute sequencer: state register plus latched opcode; all
// outputs decode from these so reset clears them without a clock edge.
//
// state | meaning
// IDLE  | waiting for start, all outputs low
// F1    | PC -> AR
// F2    | RAM read, PC increment
// F3    | RAM data -> DR
// F4    | DR -> IR
// DEC   | opcode captured into op_q
// E1-E4 | execute steps of the captured opcode
// HALT  | stopped until reset
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int SEL_W    = 4,
    parameter int NREG_WE  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                z_flag,
    output logic [NREG_WE-1:0]  c_bus_we,
    output logic [SEL_W-1:0]    bus_sel,
    output logic                pc_inc,
    output logic                ac_inc,
    output logic                ra_inc,
    output logic                rb_inc,
    output logic                rc_inc,
    output logic                ldir,
    output logic                dr_read,
    output logic                mem_read,
    output logic                mem_write,
    output logic [2:0]          alu_op,
    output logic                halted,
    output logic                illegal
);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    ctrl_out_t           outs;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_F1;
            ST_F1:   state_d = ST_F2;
            ST_F2:   state_d = ST_F3;
            ST_F3:   state_d = ST_F4;
            ST_F4:   state_d = ST_DEC;
            ST_DEC: begin
                op_d    = ir_opcode;
                state_d = (ir_opcode[5:0] == OP_HALT) ? ST_HALT : ST_E1;
            end
            ST_E1:   state_d = (exec_len(op_q[5:0]) > 3'd1) ? ST_E2 : ST_F1;
            ST_E2:   state_d = (exec_len(op_q[5:0]) > 3'd2) ? ST_E3 : ST_F1;
            ST_E3:   state_d = (exec_len(op_q[5:0]) > 3'd3) ? ST_E4 : ST_F1;
            ST_E4:   state_d = ST_F1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    ctrl_out_decode u_decode (
        .state  (state_q),
        .opcode (op_q[5:0]),
        .z_flag (z_flag),
        .outs   (outs)
    );

    assign c_bus_we  = outs.c_bus_we;
    assign bus_sel   = outs.bus_sel;
    assign pc_inc    = outs.pc_inc;
    assign ac_inc    = outs.ac_inc;
    assign ra_inc    = outs.ra_inc;
    assign rb_inc    = outs.rb_inc;
    assign rc_inc    = outs.rc_inc;
    assign ldir      = outs.ldir;
    assign dr_read   = outs.dr_read;
    assign mem_read  = outs.mem_read;
    assign mem_write = outs.mem_write;
    assign alu_op    = outs.alu_op;
    assign halted    = outs.halted;
    assign illegal   = outs.illegal;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit that drives the processor's register file/bus datapath. Runs fetch–decode–execute as a Moore FSM and produces:
- C-bus write enables
- B-bus mux select
- increment strobes, IR load, DR read-from-RAM strobe
- RAM read/write, ALU op

It consumes the IR opcode and the ALU zero flag. It sits between instruction memory/ALU and the register unit as the sole initiator of datapath transfers.

Parameters:
- OPCODE_W, 6, width of opcode from IR
- SEL_W, 4, width of B-bus mux select
- NREG_WE, 10, number of C-bus write enables

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; leave IDLE and begin fetching
- ir_opcode  input  OPCODE_W  opcode currently held in IR
- z_flag  input  1  ALU zero flag (AC==0)
- c_bus_we  output  NREG_WE  write enables: [9]PC [8]RA [7]RB [6]RC [5]R1 [4]R2 [3]R3 [2]DR [1]AR [0]AC
- bus_sel  output  SEL_W  B-bus source: 0 AR, 1 DR, 2 R1, 3 R2, 4 R3, 5 RA, 6 RB, 7 RC, 8 AC, 9 PC
- pc_inc, ac_inc, ra_inc, rb_inc, rc_inc  output  1 each  increment strobes
- ldir  output  1  load IR from DR
- dr_read  output  1  DR captures RAM data
- mem_read, mem_write  output  1 each  RAM strobes
- alu_op  output  3  0 NOP, 1 PASS, 2 ADD, 3 SUB
- halted  output  1  high while in HALT
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset (async, rst_n low): state=IDLE. Every output is 0 (bus_sel=0, alu_op=0). Outputs decode from state only, so they return to 0 immediately on reset assertion, including mid-instruction and mid-mem_write.
- IDLE: all outputs 0. Go to F1 on the first clk edge with start=1.
- RAM has 1-cycle read latency; writes take effect in the cycle mem_write is high.
- Fetch, 4 cycles:
  - F1: bus_sel=PC, alu_op=PASS, we[AR].
  - F2: mem_read, pc_inc.
  - F3: mem_read, dr_read.
  - F4: ldir.
  - Then DEC (1 cycle, no outputs), where opcode is sampled into an internal register. That register is used for all EXEC states.
- Opcode fields: [5:3] class, [2:0] reg index (0 R1, 1 R2, 2 R3, 3 RA, 4 RB, 5 RC, 6 AC, 7 illegal).
- Class 000, misc:
  - 000000 NOP: back to F1.
  - 000001 LDAC, AC<=M[RA]: E1 sel RA, PASS, we[AR]; E2 mem_read; E3 mem_read, dr_read; E4 sel DR, PASS, we[AC].
  - 000010 STAC, M[RA]<=AC: E1 sel RA, PASS, we[AR]; E2 sel AC, PASS, we[DR]; E3 mem_write.
  - 000011 JUMP: E1 sel RA, PASS, we[PC].
  - 000100 JMPZ: same as JUMP if z_flag=1 (sampled in E1); otherwise no outputs in E1.
  - 000111 HALT: enter HALT. halted=1, all other outputs 0. Only reset exits HALT.
- Class 001, MVTO rX<=AC: E1 sel AC, PASS, we[rX].
- Class 010, MVFR AC<=rX: E1 sel rX, PASS, we[AC].
- Class 011 ADD / class 100 SUB: E1 sel rX, alu_op ADD/SUB, we[AC].
- Class 101, INC: E1 asserts the inc strobe for rX. Legal rX is RA/RB/RC/AC only.
- Illegal cases: class 11x, undefined misc code, reg index 7, AC used as rX in classes 001–100, or INC of R1–R3.
  - Behave as NOP.
  - Pulse illegal for exactly the E1 cycle.
- After the final EXEC state, return to F1. start is ignored after leaving IDLE.
- Invariants:
  - At most one c_bus_we bit high per cycle.
  - mem_read and mem_write never high together.
  - No inc strobe in the same cycle as a we to the same register.
- PC wrap-around is the register's concern, not the sequencer's.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (IDLE, F1–F4, DEC, E1–E4, HALT)
  - opcode class/misc constants
  - bus_sel codes, c_bus_we bit indices, alu_op codes
- One combinational sub-module, ctrl_out_decode, maps (state, latched opcode, z_flag) to the full output vector.
- The FSM and opcode register stay in control_sequencer.

Test Plan:
- Reset then start=1 with ir_opcode=000000 -> F1 on next edge: bus_sel=9, alu_op=1, c_bus_we=10'h002; F2 pc_inc=1 and mem_read=1; F4 ldir=1; F1 again 6 cycles after the first F1.
- LDAC (000001) -> E1 c_bus_we=10'h002, bus_sel=5; E3 dr_read=1 and mem_read=1; E4 bus_sel=1, c_bus_we=10'h001; 9 cycles total from F1.
- JMPZ (000100): z_flag=1 -> E1 c_bus_we=10'h200, bus_sel=5. z_flag=0 -> E1 c_bus_we=0.
- ADD R2 (011001) -> E1 bus_sel=3, alu_op=2, c_bus_we=10'h001. INC RB (101100) -> E1 rb_inc=1, c_bus_we=0.
- Illegal (110000 and 001110) -> illegal high for exactly 1 cycle, all other outputs 0, then F1. HALT (000111) -> halted=1 held for 20 cycles despite start toggling.
- rst_n low during STAC E3 (mem_write=1) -> mem_write=0 with no clock edge. After release, outputs stay 0 in IDLE until start.
